// File: rtl/l2_cache.sv
// Direct-mapped, write-back, write-allocate L2 cache with register-based storage.
// Optional perf counters (hit/miss/writeback) are enabled by defining L2_PERF_CNT_EN.
module l2_cache #(
  parameter int s_offset = 5,
  parameter int s_index  = 3,
  parameter int s_tag    = 32 - s_offset - s_index,
  parameter int s_line   = 8 * 2**s_offset
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       mem_address,
  input  logic [s_line-1:0] mem_wdata,
  output logic              mem_resp,
  output logic [s_line-1:0] mem_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [31:0]       pmem_address,
  output logic [s_line-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [s_line-1:0] pmem_rdata
`ifdef L2_PERF_CNT_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count,
  output logic [31:0]       wb_count
`endif
);

  localparam int NLINES = 2**s_index;

  typedef enum logic [1:0] {IDLE, LOOKUP, WRITEBACK, FILL} state_t;

  state_t                    state_q, state_d;
  logic [s_line-1:0]         data_q [NLINES];
  logic [s_tag-1:0]          tag_q  [NLINES];
  logic [NLINES-1:0]         valid_q, valid_d;
  logic [NLINES-1:0]         dirty_q, dirty_d;
  logic [s_tag+s_index-1:0]  laddr_q, laddr_d;
  logic                      first_q, first_d;

  logic                      req;
  logic [s_index-1:0]        idx;
  logic [s_tag-1:0]          req_tag;
  logic                      hit;
  logic                      data_we;
  logic                      tag_we;
  logic [s_line-1:0]         data_wline;
  logic                      hit_inc, miss_inc, wb_inc;
  logic                      unused_offset;

  assign unused_offset = ^mem_address[s_offset-1:0];

  // The line address is captured on entry to LOOKUP so pmem outputs stay
  // stable even if the requester drops out mid-transaction.
  assign req     = mem_read | mem_write;
  assign idx     = laddr_q[s_index-1:0];
  assign req_tag = laddr_q[s_tag+s_index-1:s_index];
  assign hit     = valid_q[idx] && (tag_q[idx] == req_tag);

  always_comb begin
    state_d      = state_q;
    laddr_d      = laddr_q;
    first_d      = first_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    data_we      = 1'b0;
    tag_we       = 1'b0;
    data_wline   = mem_wdata;
    mem_resp     = 1'b0;
    mem_rdata    = data_q[idx];
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = data_q[idx];
    hit_inc      = 1'b0;
    miss_inc     = 1'b0;
    wb_inc       = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          laddr_d = mem_address[31:s_offset];
          first_d = 1'b1;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        first_d = 1'b0;
        if (!req) begin
          state_d = IDLE;
        end else if (hit) begin
          hit_inc  = first_q;
          mem_resp = 1'b1;
          if (mem_write) begin
            data_we      = 1'b1;
            dirty_d[idx] = 1'b1;
          end
          state_d = IDLE;
        end else begin
          miss_inc = first_q;
          state_d  = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : FILL;
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q[idx], idx, {s_offset{1'b0}}};
        if (pmem_resp) begin
          wb_inc       = 1'b1;
          dirty_d[idx] = 1'b0;
          state_d      = FILL;
        end
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {req_tag, idx, {s_offset{1'b0}}};
        if (pmem_resp) begin
          data_we      = 1'b1;
          data_wline   = pmem_rdata;
          tag_we       = 1'b1;
          valid_d[idx] = 1'b1;
          dirty_d[idx] = 1'b0;
          state_d      = LOOKUP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      laddr_q <= '0;
      first_q <= 1'b0;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      laddr_q <= laddr_d;
      first_q <= first_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Line storage carries no reset; valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (data_we) data_q[idx] <= data_wline;
    if (tag_we)  tag_q[idx]  <= req_tag;
  end

`ifdef L2_PERF_CNT_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;
  logic [31:0] wb_count_q, wb_count_d;

  always_comb begin
    hit_count_d  = hit_count_q  + {31'b0, hit_inc};
    miss_count_d = miss_count_q + {31'b0, miss_inc};
    wb_count_d   = wb_count_q   + {31'b0, wb_inc};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
      wb_count_q   <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      wb_count_q   <= wb_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
  assign wb_count   = wb_count_q;
`else
  logic unused_perf;
  assign unused_perf = hit_inc ^ miss_inc ^ wb_inc;
`endif

endmodule

// File: tb/tb_l2_cache.sv
// Directed bench for l2_cache: a line-level cache/memory model predicts every
// response and downstream transaction; a negedge monitor compares against it.
module tb_l2_cache;
  typedef logic [255:0] line_t;

  logic        clk, rst;
  logic        mem_read, mem_write, mem_resp;
  logic [31:0] mem_address;
  line_t       mem_wdata, mem_rdata;
  logic        pmem_read, pmem_write, pmem_resp;
  logic [31:0] pmem_address;
  line_t       pmem_wdata, pmem_rdata;
`ifdef L2_PERF_CNT_EN
  logic [31:0] hit_count, miss_count, wb_count;
`endif

  l2_cache dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
`ifdef L2_PERF_CNT_EN
    , .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  function automatic void chk(string nm, line_t got, line_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endfunction

  // Model: backing memory plus per-index cache state
  line_t       mem_model [logic [31:0]];
  bit          m_valid [8];
  bit          m_dirty [8];
  logic [23:0] m_tag   [8];
  line_t       m_data  [8];
  int          h_cnt = 0, ms_cnt = 0, w_cnt = 0;

  function automatic line_t mem_rd(logic [31:0] a);
    return mem_model.exists(a) ? mem_model[a] : '0;
  endfunction

  // Expectations shared with the monitor
  bit          req_active = 0, exp_read = 0, exp_wb = 0, exp_fill = 0;
  logic [31:0] exp_wb_addr = 0, exp_fill_addr = 0;
  line_t       exp_wb_data = 0, exp_rdata = 0;
  int          resp_cnt = 0;
  int          n_wb = 0, n_fill = 0;
  logic [31:0] last_wb_addr = 0;
  line_t       last_wb_data = 0;

  // Downstream memory: answers each transaction 5 cycles after it appears
  initial begin
    int cnt;
    cnt = 0;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      pmem_resp = 1'b0;
      if (rst) cnt = 0;
      else if (pmem_read || pmem_write) begin
        cnt++;
        if (cnt == 5) begin
          cnt = 0;
          pmem_resp = 1'b1;
          if (pmem_read) begin
            pmem_rdata = mem_rd(pmem_address);
            n_fill++;
          end else begin
            last_wb_addr = pmem_address;
            last_wb_data = pmem_wdata;
            n_wb++;
          end
        end
      end else cnt = 0;
    end
  end

  // Monitor
  initial begin
    bit p_act, p_rd, p_wr, p_resp;
    logic [31:0] p_addr;
    line_t p_wd;
    p_act = 0; p_rd = 0; p_wr = 0; p_resp = 0; p_addr = 0; p_wd = 0;
    forever begin
      @(negedge clk);
      if (rst) p_act = 0;
      else begin
        chk("pmem_rd_wr_excl", line_t'(pmem_read && pmem_write), 0);
        if (mem_resp) begin
          resp_cnt++;
          chk("resp_while_req", line_t'(req_active), 1);
          if (exp_read && req_active) chk("mem_rdata", mem_rdata, exp_rdata);
        end
        if (pmem_write) begin
          chk("wb_expected", line_t'(exp_wb), 1);
          chk("wb_addr", line_t'(pmem_address), line_t'(exp_wb_addr));
          chk("wb_data", pmem_wdata, exp_wb_data);
        end
        if (pmem_read) begin
          chk("fill_expected", line_t'(exp_fill), 1);
          chk("fill_addr", line_t'(pmem_address), line_t'(exp_fill_addr));
        end
        if (p_act && !p_resp) begin
          chk("pmem_rd_stable", line_t'(pmem_read), line_t'(p_rd));
          chk("pmem_wr_stable", line_t'(pmem_write), line_t'(p_wr));
          chk("pmem_addr_stable", line_t'(pmem_address), line_t'(p_addr));
          if (p_wr) chk("pmem_wdata_stable", pmem_wdata, p_wd);
        end
        p_act  = pmem_read || pmem_write;
        p_rd   = pmem_read;
        p_wr   = pmem_write;
        p_addr = pmem_address;
        p_wd   = pmem_wdata;
        p_resp = pmem_resp;
      end
    end
  end

  // mode 0: normal; 1: drop request once fill starts; 2: reset mid-fill
  task automatic do_req(input bit rd, input bit wr, input logic [31:0] addr,
                        input line_t wd, input int mode, output line_t got);
    logic [2:0]  idx;
    logic [23:0] tg;
    bit hit, done;
    int nwb0, nf0, lat, fr, fw;
    idx = addr[7:5];
    tg  = addr[31:8];
    hit = m_valid[idx] && (m_tag[idx] == tg);
    @(posedge clk); #1;
    exp_wb      = !hit && m_valid[idx] && m_dirty[idx];
    exp_wb_addr = {m_tag[idx], idx, 5'b0};
    exp_wb_data = m_data[idx];
    if (exp_wb) mem_model[exp_wb_addr] = m_data[idx];
    exp_fill      = !hit;
    exp_fill_addr = {addr[31:5], 5'b0};
    exp_rdata     = hit ? m_data[idx] : mem_rd(exp_fill_addr);
    exp_read      = !wr;
    nwb0 = n_wb; nf0 = n_fill; resp_cnt = 0;
    fr = -1; fw = -1; lat = -1; done = 0; got = '0;
    mem_read = rd; mem_write = wr; mem_address = addr; mem_wdata = wd;
    req_active = 1;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge clk);
      if (pmem_read && fr < 0) fr = cyc;
      if (pmem_write && fw < 0) fw = cyc;
      if (mode == 0 && mem_resp) begin got = mem_rdata; lat = cyc; done = 1; end
      if (mode == 1 && fr >= 0) done = 1;
      if (mode == 2 && fr >= 0 && cyc >= fr + 2) done = 1;
    end
    chk("req_timeout", line_t'(done), 1);
    if (mode == 2) begin
      #2 rst = 1'b1;
      #1;
      chk("rst_pmem_read", line_t'(pmem_read), 0);
      chk("rst_pmem_write", line_t'(pmem_write), 0);
      chk("rst_pmem_addr", line_t'(pmem_address), 0);
      chk("rst_mem_resp", line_t'(mem_resp), 0);
      mem_read = 0; mem_write = 0; req_active = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin m_valid[i] = 0; m_dirty[i] = 0; end
      h_cnt = 0; ms_cnt = 0; w_cnt = 0;
      return;
    end
    @(posedge clk); #1;
    mem_read = 0; mem_write = 0; req_active = 0;
    if (mode == 1) begin
      for (int i = 0; i < 50 && n_fill == nf0; i++) @(negedge clk);
      repeat (4) @(negedge clk);
      chk("drop_no_resp", line_t'(resp_cnt), 0);
    end else begin
      chk("resp_once", line_t'(resp_cnt), 1);
      if (hit) chk("hit_latency", line_t'(lat), 1);
      else if (exp_wb) chk("wb_start_cycle", line_t'(fw), 2);
      else chk("fill_start_cycle", line_t'(fr), 2);
    end
    chk("n_writebacks", line_t'(n_wb - nwb0), line_t'(exp_wb));
    chk("n_fills", line_t'(n_fill - nf0), line_t'(exp_fill));
    if (hit) h_cnt++; else ms_cnt++;
    if (exp_wb) w_cnt++;
    m_valid[idx] = 1;
    m_tag[idx]   = tg;
    if (wr) begin m_data[idx] = wd; m_dirty[idx] = 1; end
    else if (!hit) begin m_data[idx] = exp_rdata; m_dirty[idx] = 0; end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    line_t got;
    mem_model[32'h040] = {8{32'hAAAAAAAA}};
    mem_model[32'h140] = {8{32'h33333333}};
    mem_model[32'h060] = {8{32'h77777777}};
    mem_model[32'h160] = {8{32'h44444444}};
    mem_model[32'h080] = {8{32'h88888888}};
    mem_model[32'h0A0] = {8{32'hBBBBBBBB}};
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 0; m_dirty[i] = 0; m_tag[i] = 0; m_data[i] = 0;
    end
    rst = 1'b1;
    mem_read = 0; mem_write = 0; mem_address = 0; mem_wdata = 0;
    #1;
    chk("reset_mem_resp", line_t'(mem_resp), 0);
    chk("reset_pmem_read", line_t'(pmem_read), 0);
    chk("reset_pmem_write", line_t'(pmem_write), 0);
    chk("reset_pmem_addr", line_t'(pmem_address), 0);
`ifdef L2_PERF_CNT_EN
    chk("reset_hit_count", line_t'(hit_count), 0);
    chk("reset_miss_count", line_t'(miss_count), 0);
    chk("reset_wb_count", line_t'(wb_count), 0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    do_req(1, 0, 32'h0000_0040, '0, 0, got);
    chk("cold_read_data", got, {8{32'hAAAAAAAA}});
    do_req(1, 0, 32'h0000_0040, '0, 0, got);
    do_req(0, 1, 32'h0000_0040, {8{32'h55555555}}, 0, got);
    do_req(1, 0, 32'h0000_0140, '0, 0, got);
    chk("evict_wb_addr", line_t'(last_wb_addr), 32'h40);
    chk("evict_wb_data", last_wb_data, {8{32'h55555555}});
    chk("evict_read_data", got, {8{32'h33333333}});

    do_req(0, 1, 32'h0000_0060, {8{32'h11111111}}, 0, got);
    do_req(1, 0, 32'h0000_0160, '0, 0, got);
    chk("wmiss_wb_addr", line_t'(last_wb_addr), 32'h60);
    chk("wmiss_wb_data", last_wb_data, {8{32'h11111111}});
    do_req(1, 0, 32'h0000_0060, '0, 0, got);
    chk("refetch_written", got, {8{32'h11111111}});

    do_req(0, 1, 32'h0000_0140, {8{32'h99999999}}, 0, got);
    do_req(1, 0, 32'h0000_0080, '0, 2, got);

    do_req(1, 0, 32'h0000_0040, '0, 0, got);
    chk("post_rst_read", got, {8{32'h55555555}});
    do_req(0, 1, 32'h0000_0040, {8{32'hCCCCCCCC}}, 0, got);
    do_req(1, 0, 32'h0000_0140, '0, 0, got);
    chk("dirty_lost_on_rst", got, {8{32'h33333333}});
    chk("post_rst_wb_data", last_wb_data, {8{32'hCCCCCCCC}});
`ifdef L2_PERF_CNT_EN
    @(negedge clk);
    chk("perf_hit_lit", line_t'(hit_count), 1);
    chk("perf_miss_lit", line_t'(miss_count), 2);
    chk("perf_wb_lit", line_t'(wb_count), 1);
`endif

    do_req(1, 0, 32'h0000_00A0, '0, 1, got);
    do_req(1, 0, 32'h0000_00A0, '0, 0, got);
    chk("after_drop_data", got, {8{32'hBBBBBBBB}});
    do_req(1, 1, 32'h0000_00A0, {8{32'hDDDDDDDD}}, 0, got);
    do_req(1, 0, 32'h0000_00A0, '0, 0, got);
    chk("rw_as_write", got, {8{32'hDDDDDDDD}});

`ifdef L2_PERF_CNT_EN
    @(negedge clk);
    chk("perf_hit_model", line_t'(hit_count), line_t'(h_cnt));
    chk("perf_miss_model", line_t'(miss_count), line_t'(ms_cnt));
    chk("perf_wb_model", line_t'(wb_count), line_t'(w_cnt));
`endif
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
